octal_char_streamer: RTL and testbench
======================================

// Module: octal_char_streamer
// PURPOSE
//  Sequencer and consumer for the octal digit-select mux. Accepts one signed 32-bit word per
//  transaction and holds it on mux_d. It steps the mux index 0..10 and reads back the sign flag
//  and each 3-bit group. It emits the value as an ASCII octal string on a valid/ready byte stream:
//  an optional '-' first, then digits most-significant first, with leading zeros suppressed.
//  It sits between the word source and the UART/display character sink.
// PARAMETERS
//  SUPPRESS_ZEROS  1      1: drop leading zero digits; 0: always emit all 11 digits
//  CHAR_ZERO       8'h30  ASCII code added to the digit value
//  CHAR_MINUS      8'h2D  ASCII code emitted for negative inputs
// PORTS
//  clk        in   1   single clock, all state updates on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   in_data valid
//  in_ready   out  1   block idle, can accept a word
//  in_data    in   32  signed input word
//  mux_d      out  32  latched word driven to digit mux D input
//  mux_i      out  4   digit group index driven to digit mux (0 = bits[31:30], 10 = bits[2:0])
//  mux_sign   in   1   from mux: 0 = negative, 1 = non-negative
//  mux_digit  in   3   from mux: selected 3-bit magnitude group (combinational from mux_d, mux_i)
//  out_valid  out  1   out_data valid
//  out_ready  in   1   sink accepts byte
//  out_data   out  8   ASCII character
//  out_last   out  1   marks final character of the string
// BEHAVIOUR
//  - Reset values: state=IDLE, mux_d=0, mux_i=0, in_ready=1, out_valid=0, out_data=0, out_last=0,
//    seen_nz=0.
//  - Reset has priority over all events. A reset mid-string abandons it: no further bytes and no
//    out_last. out_valid is 0 in the cycle after the reset edge.
//  - States:
//    - IDLE: in_ready=1. On in_valid: latch mux_d<=in_data, mux_i<=0, seen_nz<=0; go to SIGN.
//      in_ready=0 in all other states, and in_valid there is ignored.
//    - SIGN, mux_sign=0: out_valid=1, out_data=CHAR_MINUS, out_last=0. Hold until out_ready, then
//      go to DIGITS.
//    - SIGN, mux_sign=1: no byte; go to DIGITS next edge (one cycle).
//    - DIGITS, skip case: SUPPRESS_ZEROS=1 and seen_nz=0 and mux_digit==0 and mux_i!=10. No byte;
//      mux_i<=mux_i+1 next edge (one cycle per skipped digit).
//    - DIGITS, otherwise: out_valid=1, out_data=CHAR_ZERO+mux_digit, out_last=(mux_i==10).
//      On out_valid&&out_ready: seen_nz<=1. If mux_i==10, mux_i<=0 and go to IDLE; else mux_i+1.
//  - Because mux_i 10 is never skipped, zero emits the single character "0".
//  - out_valid/out_data/out_last derive only from registered state, mux_d, mux_i and seen_nz,
//    plus the mux's combinational digit path. There is no combinational path from out_ready.
//    While out_valid && !out_ready, out_data and out_last are held stable.
//  - Magnitude comes from the mux (two's-complement negate). -2^31 yields "-20000000000".
//  - String length is 1..12 bytes. mux_i never exceeds 10 and never wraps past 10.
//  - Latency: in_valid accepted at edge T. For a positive word, the first digit is presented at
//    T+1+1+(skipped digits) with out_ready=1. A negative word presents '-' at T+1.
//  - Throughput: next word accepted in the cycle after the out_last handshake (IDLE, in_ready=1).
// TESTING
//  1. D=0, out_ready=1 -> single byte 0x30 with out_last=1; in_ready back to 1 next cycle.
//  2. D=8 -> "10" (0x31,0x30), last on 0x30. D=32'h7FFFFFFF -> "17777777777", 11 bytes.
//  3. D=-1 -> "-1" (0x2D,0x31). D=32'h80000000 -> "-20000000000", 12 bytes, last on 12th.
//  4. D=-83 (octal 123) with out_ready toggled 1,0,0,1 per cycle -> "-123".
//     out_data/out_last stable while stalled; in_valid pulses during the string are not accepted.
//  5. D=511 streaming, rst pulsed after the 2nd byte -> outputs at reset values next cycle.
//     Following D=7 -> "7" only.
//  6. SUPPRESS_ZEROS=0, D=5 -> "00000000005" (11 bytes). D=-5 -> "-00000000005".

Source files
------------

// File: rtl/octal_char_streamer.sv
// Octal string streamer: latches a signed word onto the digit mux, walks the mux index
// and emits '-' plus octal digits (MSD first, optional leading-zero suppression) as bytes.
module octal_char_streamer #(
    parameter int         SUPPRESS_ZEROS = 1,
    parameter logic [7:0] CHAR_ZERO      = 8'h30,
    parameter logic [7:0] CHAR_MINUS     = 8'h2D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [31:0] mux_d,
    output logic [3:0]  mux_i,
    input  logic        mux_sign,
    input  logic [2:0]  mux_digit,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // A producer holding valid keeps its data stable until the transfer; out_valid never
    // depends combinationally on out_ready.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SIGN   = 2'd1,
        DIGITS = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] mux_d_nxt;
    logic [3:0]  mux_i_nxt;
    logic        seen_nz, seen_nz_nxt;
    logic        skip;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mux_d   <= 32'd0;
            mux_i   <= 4'd0;
            seen_nz <= 1'b0;
        end else begin
            state   <= state_nxt;
            mux_d   <= mux_d_nxt;
            mux_i   <= mux_i_nxt;
            seen_nz <= seen_nz_nxt;
        end
    end

    // Index 10 is never skipped, so a zero word still produces "0".
    assign skip = (SUPPRESS_ZEROS != 0) && !seen_nz && (mux_digit == 3'd0) && (mux_i != 4'd10);

    always_comb begin
        state_nxt   = state;
        mux_d_nxt   = mux_d;
        mux_i_nxt   = mux_i;
        seen_nz_nxt = seen_nz;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = 8'd0;
        out_last    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mux_d_nxt   = in_data;
                    mux_i_nxt   = 4'd0;
                    seen_nz_nxt = 1'b0;
                    state_nxt   = SIGN;
                end
            end
            SIGN: begin
                if (!mux_sign) begin
                    out_valid = 1'b1;
                    out_data  = CHAR_MINUS;
                    if (out_ready) state_nxt = DIGITS;
                end else begin
                    state_nxt = DIGITS;
                end
            end
            DIGITS: begin
                if (skip) begin
                    mux_i_nxt = mux_i + 4'd1;
                end else begin
                    out_valid = 1'b1;
                    out_data  = CHAR_ZERO + {5'd0, mux_digit};
                    out_last  = (mux_i == 4'd10);
                    if (out_ready) begin
                        seen_nz_nxt = 1'b1;
                        if (mux_i == 4'd10) begin
                            mux_i_nxt = 4'd0;
                            state_nxt = IDLE;
                        end else begin
                            mux_i_nxt = mux_i + 4'd1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_octal_char_streamer.sv
// Directed bench: two streamers (zero suppression on/off), each with a behavioural digit mux,
// checking emitted strings, latency, stall stability and mid-string reset.
module tb_octal_char_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_data   [2];
    logic [31:0] mux_d     [2];
    logic [3:0]  mux_i     [2];
    logic        mux_sign  [2];
    logic [2:0]  mux_digit [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [7:0]  out_data  [2];
    logic        out_last  [2];

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    octal_char_streamer #(.SUPPRESS_ZEROS(1)) dut_sz (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .mux_d(mux_d[0]), .mux_i(mux_i[0]), .mux_sign(mux_sign[0]), .mux_digit(mux_digit[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0])
    );

    octal_char_streamer #(.SUPPRESS_ZEROS(0)) dut_full (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .mux_d(mux_d[1]), .mux_i(mux_i[1]), .mux_sign(mux_sign[1]), .mux_digit(mux_digit[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1])
    );

    // Behavioural digit mux: sign flag plus 3-bit groups of the two's-complement magnitude.
    function automatic logic [2:0] group_of(input logic [31:0] d, input logic [3:0] i);
        logic [31:0] mag;
        mag = d[31] ? (~d + 32'd1) : d;
        if (i > 4'd10) return 3'd0;
        return 3'((mag >> (30 - 3 * int'(i))) & 32'd7);
    endfunction

    always_comb begin
        for (int u = 0; u < 2; u++) begin
            mux_sign[u]  = ~mux_d[u][31];
            mux_digit[u] = group_of(mux_d[u], mux_i[u]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: out_ready held high; mode 1: out_ready 1,0,0,1 per cycle with in_valid noise.
    // abort_after > 0 pulses rst after that many bytes.
    task automatic stream(input int u, input logic [31:0] d, input string s, input int mode,
                          input int abort_after, input int lat);
        int cyc, first, nb, exp_n;
        bit done, held, hl;
        logic [7:0] hd, e;
        exp_q.delete();
        for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
        exp_n = (abort_after > 0) ? abort_after : s.len();

        @(negedge clk);
        check("in_ready_idle", 32'(in_ready[u]), 32'd1);
        @(posedge clk); #1;
        in_valid[u]  = 1'b1;
        in_data[u]   = d;
        out_ready[u] = 1'b1;
        @(posedge clk); #1;
        in_valid[u] = (mode == 1);
        in_data[u]  = 32'h0000_0001;

        cyc = 0; first = -1; nb = 0; done = 0; held = 0; hd = 8'd0; hl = 0;
        while (!done && cyc < 60) begin
            cyc++;
            out_ready[u] = (mode == 0) ? 1'b1 : ((cyc % 4 == 1) || (cyc % 4 == 0));
            @(negedge clk);
            if (cyc == 1) check("mux_d_latched", mux_d[u], d);
            if (mode == 1) check("in_ready_busy", 32'(in_ready[u]), 32'd0);
            if (held && out_valid[u]) begin
                check("stall_data", 32'(out_data[u]), 32'(hd));
                check("stall_last", 32'(out_last[u]), 32'(hl));
            end
            held = out_valid[u] && !out_ready[u];
            hd   = out_data[u];
            hl   = out_last[u];
            if (out_valid[u] && first < 0) first = cyc;
            if (out_valid[u] && out_ready[u]) begin
                nb++;
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'(out_data[u]), 32'hFFFF);
                    done = 1;
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 32'(out_data[u]), 32'(e));
                    check("last", 32'(out_last[u]), 32'(exp_q.size() == 0));
                end
                if (out_last[u]) begin
                    done = 1;
                    in_valid[u] = 1'b0;
                end
                if (nb == abort_after) done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid[u] = 1'b0;
        if (!done) check("timeout", 32'd1, 32'd0);
        check("first_latency", 32'(first), 32'(lat));
        check("byte_count", 32'(nb), 32'(exp_n));

        if (abort_after > 0) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid[u]), 32'd0);
            check("rst_out_data", 32'(out_data[u]), 32'd0);
            check("rst_out_last", 32'(out_last[u]), 32'd0);
            check("rst_in_ready", 32'(in_ready[u]), 32'd1);
            check("rst_mux_i", 32'(mux_i[u]), 32'd0);
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("post_rst_quiet", 32'(out_valid[u]), 32'd0);
            end
        end else begin
            @(negedge clk);
            check("in_ready_after_last", 32'(in_ready[u]), 32'd1);
            check("idle_out_valid", 32'(out_valid[u]), 32'd0);
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            in_data[u]   = 32'd0;
            out_ready[u] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset_in_ready", 32'(in_ready[u]), 32'd1);
            check("reset_out_valid", 32'(out_valid[u]), 32'd0);
            check("reset_out_data", 32'(out_data[u]), 32'd0);
            check("reset_out_last", 32'(out_last[u]), 32'd0);
            check("reset_mux_d", mux_d[u], 32'd0);
            check("reset_mux_i", 32'(mux_i[u]), 32'd0);
        end
        rst = 1'b0;

        stream(0, 32'd0,          "0",            0, 0, 12);
        stream(0, 32'd8,          "10",           0, 0, 11);
        stream(0, 32'h7FFF_FFFF,  "17777777777",  0, 0, 2);
        stream(0, 32'hFFFF_FFFF,  "-1",           0, 0, 1);
        stream(0, 32'h8000_0000,  "-20000000000", 0, 0, 1);
        stream(0, -32'sd83,       "-123",         1, 0, 1);
        stream(0, 32'd511,        "777",          0, 2, 10);
        stream(0, 32'd7,          "7",            0, 0, 12);
        stream(1, 32'd5,          "00000000005",  0, 0, 2);
        stream(1, -32'sd5,        "-00000000005", 0, 0, 1);
        stream(1, 32'd0,          "00000000000",  1, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
